// File: rtl/prco_fetch_pkg.sv
// prco_fetch_pkg
//   Shared constants and state encoding for the prco instruction fetch
//   sequencer.
//   Contents:
//     ADDR_W          fetch address / PC width
//     HALT_INSTR_DEF  default instruction word that stops fetching
//     WAIT_CNT_W      width of the memory-wait counter
//     state_t         fetch FSM state encoding
//   Optional feature macro: PRCO_FETCH_BRK_EN (adds the S_BRK state).
package prco_fetch_pkg;

    localparam int          ADDR_W         = 16;
    localparam logic [15:0] HALT_INSTR_DEF = 16'hFFFF;
    localparam int          WAIT_CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_EXEC = 3'd3,
        S_HALT = 3'd4
`ifdef PRCO_FETCH_BRK_EN
        , S_BRK = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/prco_fetch.sv
// prco_fetch
//   Instruction fetch sequencer sitting directly upstream of prco_lmem.
//   Owns the PC, issues a one-cycle fetch strobe, latches the returned word,
//   pulses the decoder, then advances or branches when the pipeline retires
//   the instruction.
//
//   Optional feature macro: PRCO_FETCH_BRK_EN
//     Adds i_brk_addr / i_brk_resume and the S_BRK breakpoint state.
//
//   Ports:
//     i_clk          clock, rising edge
//     i_reset        asynchronous active-low reset
//     i_start        level, leave IDLE and begin fetching
//     i_ce_next      pulse, current instruction retired
//     i_branch_en    take branch (sampled with i_ce_next only)
//     i_branch_addr  branch target
//     i_mem_ce_dec   memory data-valid pulse
//     i_mem_douta    memory read data
//     i_brk_addr     breakpoint address          (PRCO_FETCH_BRK_EN only)
//     i_brk_resume   leave breakpoint, refetch    (PRCO_FETCH_BRK_EN only)
//     q_ce_fetch     one-cycle fetch strobe to memory
//     q_mem_addr     fetch address (always q_pc)
//     q_pc           current program counter
//     q_instr        latched instruction word
//     q_ce_dec       one-cycle pulse to decoder, q_instr valid
//     q_halted       fetch stopped (halt word, timeout or breakpoint)
//     q_err          memory timeout, sticky until reset
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | after reset, waiting for i_start
//   S_REQ  | fetch strobe to memory at q_pc, wait counter cleared
//   S_WAIT | waiting for memory data, bounded by P_WAIT_MAX cycles
//   S_EXEC | instruction handed to decoder, waiting for retirement
//   S_HALT | terminal: halt word or memory timeout, only reset leaves
//   S_BRK  | breakpoint hit on next PC, waiting for i_brk_resume
module prco_fetch
    import prco_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] P_RESET_PC   = 16'h0000,
    parameter logic [15:0]       P_HALT_INSTR = HALT_INSTR_DEF,
    parameter int unsigned       P_WAIT_MAX   = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_ce_next,
    input  logic              i_branch_en,
    input  logic [ADDR_W-1:0] i_branch_addr,
    input  logic              i_mem_ce_dec,
    input  logic [15:0]       i_mem_douta,
`ifdef PRCO_FETCH_BRK_EN
    input  logic [ADDR_W-1:0] i_brk_addr,
    input  logic              i_brk_resume,
`endif
    output logic              q_ce_fetch,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic [ADDR_W-1:0] q_pc,
    output logic [15:0]       q_instr,
    output logic              q_ce_dec,
    output logic              q_halted,
    output logic              q_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX_C = WAIT_CNT_W'(P_WAIT_MAX);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       pc_q, pc_d, pc_next;
    logic [15:0]             instr_q, instr_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                    ce_dec_q, ce_dec_d;
    logic                    halted_q, halted_d;
    logic                    err_q, err_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            pc_q     <= P_RESET_PC;
            instr_q  <= '0;
            cnt_q    <= '0;
            ce_dec_q <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            ce_dec_q <= ce_dec_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Natural 16-bit add gives the FFFF -> 0000 wrap.
    assign pc_next = i_branch_en ? i_branch_addr : pc_q + 16'd1;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
        ce_dec_d = 1'b0;
        halted_d = halted_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_REQ;
            end

            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (i_mem_ce_dec) begin
                    instr_d = i_mem_douta;
                    if (i_mem_douta == P_HALT_INSTR) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        ce_dec_d = 1'b1;
                        state_d  = S_EXEC;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == WAIT_MAX_C) begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                end
            end

            S_EXEC: begin
                if (i_ce_next) begin
                    pc_d    = pc_next;
                    state_d = S_REQ;
`ifdef PRCO_FETCH_BRK_EN
                    // Break on the address about to be fetched; PC is already updated.
                    if (pc_next == i_brk_addr) begin
                        halted_d = 1'b1;
                        state_d  = S_BRK;
                    end
`endif
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

`ifdef PRCO_FETCH_BRK_EN
            S_BRK: begin
                if (i_brk_resume) begin
                    halted_d = 1'b0;
                    state_d  = S_REQ;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Fetch strobe is state-decoded; decode pulse is registered on entry to
    // S_EXEC, so the two can never coincide.
    assign q_ce_fetch = (state_q == S_REQ);
    assign q_mem_addr = pc_q;
    assign q_pc       = pc_q;
    assign q_instr    = instr_q;
    assign q_ce_dec   = ce_dec_q;
    assign q_halted   = halted_q;
    assign q_err      = err_q;

endmodule

// File: tb/tb_prco_fetch.sv
// tb_prco_fetch
//   Scoreboard bench for prco_fetch. A small memory responder answers fetch
//   strobes one cycle later; expected fetch addresses and decoded words are
//   queued by the stimulus and checked by an independent monitor.
//   A second instance with P_RESET_PC=16'hFFFF covers PC wrap.
module tb_prco_fetch;

    logic        clk = 1'b0;
    logic        rst_a, rst_w;
    logic        start, ce_next, branch_en;
    logic [15:0] branch_addr;
    logic        mem_ce_dec;
    logic [15:0] douta;
    logic [15:0] brk_addr;
    logic        brk_resume;

    logic        q_ce_fetch, q_ce_dec, q_halted, q_err;
    logic [15:0] q_mem_addr, q_pc, q_instr;

    logic        start_w, ce_next_w, mem_ce_dec_w;
    logic [15:0] douta_w;
    logic        q_ce_fetch_w, q_ce_dec_w, q_halted_w, q_err_w;
    logic [15:0] q_mem_addr_w, q_pc_w, q_instr_w;

    logic [15:0] mem [16];
    logic        withhold, stale;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_fetch_cyc = 0;
    logic [15:0] exp_fetch[$];
    logic [15:0] exp_dec[$];

    localparam int W_DEC = 0, W_HALT = 1, W_FETCH = 2, W_FETCH_W = 3, W_DEC_W = 4;

    always #5 clk = ~clk;

    prco_fetch #(.P_RESET_PC(16'h0000)) dut (
        .i_clk(clk), .i_reset(rst_a), .i_start(start), .i_ce_next(ce_next),
        .i_branch_en(branch_en), .i_branch_addr(branch_addr),
        .i_mem_ce_dec(mem_ce_dec), .i_mem_douta(douta),
`ifdef PRCO_FETCH_BRK_EN
        .i_brk_addr(brk_addr), .i_brk_resume(brk_resume),
`endif
        .q_ce_fetch(q_ce_fetch), .q_mem_addr(q_mem_addr), .q_pc(q_pc),
        .q_instr(q_instr), .q_ce_dec(q_ce_dec), .q_halted(q_halted), .q_err(q_err)
    );

    prco_fetch #(.P_RESET_PC(16'hFFFF)) dut_w (
        .i_clk(clk), .i_reset(rst_w), .i_start(start_w), .i_ce_next(ce_next_w),
        .i_branch_en(branch_en), .i_branch_addr(branch_addr),
        .i_mem_ce_dec(mem_ce_dec_w), .i_mem_douta(douta_w),
`ifdef PRCO_FETCH_BRK_EN
        .i_brk_addr(brk_addr), .i_brk_resume(brk_resume),
`endif
        .q_ce_fetch(q_ce_fetch_w), .q_mem_addr(q_mem_addr_w), .q_pc(q_pc_w),
        .q_instr(q_instr_w), .q_ce_dec(q_ce_dec_w), .q_halted(q_halted_w), .q_err(q_err_w)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: data one cycle after the strobe, optionally withheld,
    // or a stray pulse on request.
    always @(posedge clk) begin
        mem_ce_dec <= 1'b0;
        if (q_ce_fetch && !withhold) begin
            mem_ce_dec <= 1'b1;
            douta      <= mem[q_mem_addr[3:0]];
        end else if (stale) begin
            mem_ce_dec <= 1'b1;
            douta      <= 16'hDEAD;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (rst_a) begin
            if (q_ce_fetch && q_ce_dec) fail("fetch_and_dec_same_cycle");
            if (q_ce_fetch) begin
                if (exp_fetch.size() == 0) fail("unexpected_fetch");
                else chk("fetch_addr", {16'h0, q_mem_addr}, {16'h0, exp_fetch.pop_front()});
                last_fetch_cyc = cyc;
            end
            if (q_ce_dec) begin
                if (exp_dec.size() == 0) fail("unexpected_dec");
                else chk("dec_instr", {16'h0, q_instr}, {16'h0, exp_dec.pop_front()});
                chk("dec_latency", cyc - last_fetch_cyc, 2);
            end
        end
    end

    function automatic bit sel(input int which);
        case (which)
            W_DEC:     return q_ce_dec;
            W_HALT:    return q_halted;
            W_FETCH:   return q_ce_fetch;
            W_FETCH_W: return q_ce_fetch_w;
            default:   return q_ce_dec_w;
        endcase
    endfunction

    task automatic wait_for(input int which, input string nm);
        int n = 0;
        while (!sel(which) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sel(which)) fail({nm, "_timeout"});
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_next(input logic br, input logic [15:0] addr);
        ce_next = 1'b1; branch_en = br; branch_addr = addr;
        @(negedge clk);
        ce_next = 1'b0; branch_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_a = 1'b0;
        @(negedge clk) rst_a = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 0; rst_w = 0; start = 0; ce_next = 0; branch_en = 0;
        branch_addr = 0; start_w = 0; ce_next_w = 0; mem_ce_dec_w = 0;
        douta_w = 0; brk_addr = 16'hF000; brk_resume = 0;
        withhold = 0; stale = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[0] = 16'h2011; mem[1] = 16'h2110; mem[2] = 16'hFFFF; mem[3] = 16'h3333;
        mem[10] = 16'h4AAA; mem[11] = 16'hFFFF;
        repeat (3) @(negedge clk);

        chk("rst_pc", {16'h0, q_pc}, 32'h0);
        chk("rst_instr", {16'h0, q_instr}, 32'h0);
        chk("rst_flags", {28'h0, q_ce_fetch, q_ce_dec, q_halted, q_err}, 32'h0);
        chk("rst_pc_w", {16'h0, q_pc_w}, 32'hFFFF);
        rst_a = 1'b1;

        // Straight-line program ending in the halt word.
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001); exp_fetch.push_back(16'h0002);
        exp_dec.push_back(16'h2011); exp_dec.push_back(16'h2110);
        pulse_start();
        wait_for(W_DEC, "t1_dec0"); pulse_next(1'b0, 16'h0);
        wait_for(W_DEC, "t1_dec1"); pulse_next(1'b0, 16'h0);
        wait_for(W_HALT, "t1_halt");
        repeat (3) @(negedge clk);
        chk("t1_halted_err", {30'h0, q_halted, q_err}, 32'h2);
        chk("t1_instr", {16'h0, q_instr}, 32'hFFFF);
        chk("t1_pc", {16'h0, q_pc}, 32'h0002);
        // HALT is terminal: none of these may move it.
        start = 1; ce_next = 1; branch_en = 1; branch_addr = 16'h0055;
        repeat (4) @(negedge clk);
        start = 0; ce_next = 0; branch_en = 0;
        chk("t1_halt_sticky", {15'h0, q_halted, q_pc}, 32'h0001_0002);
        chk("t1_queues", exp_fetch.size() + exp_dec.size(), 0);

        // Branch from PC=3 to 00AA, then sequential to 00AB (halt word).
        mem[2] = 16'h2222;
        do_reset();
        foreach (mem[i]) if (i < 0) mem[i] = 0;
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001); exp_fetch.push_back(16'h0002);
        exp_fetch.push_back(16'h0003); exp_fetch.push_back(16'h00AA); exp_fetch.push_back(16'h00AB);
        exp_dec.push_back(16'h2011); exp_dec.push_back(16'h2110); exp_dec.push_back(16'h2222);
        exp_dec.push_back(16'h3333); exp_dec.push_back(16'h4AAA);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_for(W_DEC, "t2_dec"); pulse_next(1'b0, 16'h0);
        end
        wait_for(W_DEC, "t2_dec3");
        chk("t2_pc_before_branch", {16'h0, q_pc}, 32'h0003);
        pulse_next(1'b1, 16'h00AA);
        wait_for(W_DEC, "t2_dec_br"); pulse_next(1'b0, 16'h0);
        wait_for(W_HALT, "t2_halt");
        chk("t2_pc", {16'h0, q_pc}, 32'h00AB);
        chk("t2_queues", exp_fetch.size() + exp_dec.size(), 0);

        // Timeout: no data for 4 WAIT cycles.
        do_reset();
        withhold = 1'b1;
        exp_fetch.push_back(16'h0000);
        pulse_start();
        wait_for(W_HALT, "t3_halt");
        chk("t3_err_halted", {30'h0, q_halted, q_err}, 32'h3);
        chk("t3_timeout_cycles", cyc - last_fetch_cyc, 5);
        pulse_next(1'b0, 16'h0);
        repeat (3) @(negedge clk);
        chk("t3_after_next", {14'h0, q_halted, q_err, q_pc}, 32'h0003_0000);
        withhold = 1'b0;

        // Reset mid-WAIT, stale data afterwards must be ignored.
        do_reset();
        withhold = 1'b1;
        exp_fetch.push_back(16'h0000);
        pulse_start();
        wait_for(W_FETCH, "t4_fetch");
        @(negedge clk);
        @(negedge clk) rst_a = 1'b0;
        #1;
        chk("t4_rst_async", {q_ce_fetch, q_ce_dec, q_halted, q_err, q_pc, q_instr[11:0]}, 32'h0);
        @(negedge clk) rst_a = 1'b1; stale = 1'b1; withhold = 1'b0;
        @(negedge clk) stale = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_idle_after_stale", {q_ce_fetch, q_ce_dec, q_halted, q_err, q_pc, q_instr[11:0]}, 32'h0);
        chk("t4_instr", {16'h0, q_instr}, 32'h0);
        exp_fetch.push_back(16'h0000); exp_dec.push_back(16'h2011);
        pulse_start();
        wait_for(W_DEC, "t4_dec");
        @(negedge clk);
        chk("t4_queues", exp_fetch.size() + exp_dec.size(), 0);

        // PC wrap on the FFFF-reset instance.
        @(negedge clk) rst_w = 1'b1;
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        wait_for(W_FETCH_W, "t5_fetch0");
        chk("t5_fetch_addr0", {16'h0, q_mem_addr_w}, 32'hFFFF);
        @(negedge clk) mem_ce_dec_w = 1'b1; douta_w = 16'h1234;
        @(negedge clk) mem_ce_dec_w = 1'b0;
        wait_for(W_DEC_W, "t5_dec");
        chk("t5_instr", {16'h0, q_instr_w}, 32'h1234);
        ce_next_w = 1'b1;
        @(negedge clk) ce_next_w = 1'b0;
        chk("t5_pc_wrap", {16'h0, q_pc_w}, 32'h0000);
        wait_for(W_FETCH_W, "t5_fetch1");
        chk("t5_fetch_addr1", {16'h0, q_mem_addr_w}, 32'h0000);
        @(negedge clk) rst_w = 1'b0;

`ifdef PRCO_FETCH_BRK_EN
        // Breakpoint on address 2, then resume.
        do_reset();
        brk_addr = 16'h0002;
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        exp_dec.push_back(16'h2011); exp_dec.push_back(16'h2110);
        pulse_start();
        wait_for(W_DEC, "t6_dec0"); pulse_next(1'b0, 16'h0);
        wait_for(W_DEC, "t6_dec1"); pulse_next(1'b0, 16'h0);
        repeat (3) @(negedge clk);
        chk("t6_brk", {15'h0, q_halted, q_pc}, 32'h0001_0002);
        exp_fetch.push_back(16'h0002); exp_dec.push_back(16'h2222);
        brk_resume = 1'b1;
        @(negedge clk) brk_resume = 1'b0;
        wait_for(W_DEC, "t6_dec2");
        chk("t6_resumed", {31'h0, q_halted}, 32'h0);
        brk_addr = 16'hF000;
        do_reset();
`endif

        repeat (2) @(negedge clk);
        chk("final_queues", exp_fetch.size() + exp_dec.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
